// File: rtl/multi_rate_serializer.sv
// Block-to-symbol serializer with a shift register and a one-deep holding register.
// Define SERIALIZER_GRAY_EN to Gray-code each emitted symbol.
module multi_rate_serializer #(
    parameter int DATA_W = 128,
    parameter int SYM_W = 2,
    parameter bit MSB_FIRST = 1'b1,
    localparam int NSYM = DATA_W / SYM_W,
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cipher_data,
    input  logic              load_en,
    output logic              buffer_ready,
    input  logic              mod_req,
    output logic [SYM_W-1:0]  symbol_data,
    output logic              symbol_valid,
    output logic [IDX_W-1:0]  sym_index,
    output logic              block_done,
    output logic              underrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              under_q, under_d;
    logic              ready_q;

    logic [DATA_W-1:0] shift_adv;
    logic [SYM_W-1:0]  sym_raw;
    logic              last_sym;

    assign shift_adv = MSB_FIRST ? (shift_q << SYM_W) : (shift_q >> SYM_W);
    assign sym_raw   = MSB_FIRST ? shift_q[DATA_W-1 -: SYM_W] : shift_q[SYM_W-1:0];
    assign last_sym  = (idx_q == IDX_W'(NSYM - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        full_d  = full_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        under_d = 1'b0;
        case (state_q)
            IDLE: begin
                under_d = mod_req;
                if (load_en) begin
                    shift_d = cipher_data;
                    idx_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (load_en && !full_q) begin
                    hold_d = cipher_data;
                    full_d = 1'b1;
                end
                if (mod_req) begin
                    if (!last_sym) begin
                        shift_d = shift_adv;
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (full_q) begin
                            shift_d = hold_q;
                            full_d  = 1'b0;
                        end else if (load_en) begin
                            // Direct reload keeps the stream gap-free.
                            shift_d = cipher_data;
                            hold_d  = hold_q;
                            full_d  = 1'b0;
                        end else begin
                            shift_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            under_q <= under_d;
            ready_q <= ~full_d;
        end
    end

`ifdef SERIALIZER_GRAY_EN
    assign symbol_data = sym_raw ^ (sym_raw >> 1);
`else
    assign symbol_data = sym_raw;
`endif

    assign symbol_valid = (state_q == ACTIVE);
    assign sym_index    = idx_q;
    assign block_done   = done_q;
    assign underrun     = under_q;
    assign buffer_ready = ready_q;

endmodule

// File: tb/tb_multi_rate_serializer.sv
// Scoreboard bench for multi_rate_serializer: random loads/requests vs a symbol-queue model.
module tb_multi_rate_serializer;

    localparam int DW = 128;
    localparam int SW = 2;
    localparam int NS = DW / SW;
    localparam int IW = $clog2(NS);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] cipher_data = '0;
    logic          load_en = 1'b0;
    logic          mod_req = 1'b0;
    logic          buffer_ready;
    logic [SW-1:0] symbol_data;
    logic          symbol_valid;
    logic [IW-1:0] sym_index;
    logic          block_done;
    logic          underrun;

    logic [15:0] s_data = '0;
    logic        s_load = 1'b0;
    logic        s_req = 1'b0;
    logic        s_rdy, s_valid, s_done, s_und;
    logic [3:0]  s_sym;
    logic [1:0]  s_idx;

    always #5 clk = ~clk;

    multi_rate_serializer u_dut (
        .clk(clk), .reset(reset), .cipher_data(cipher_data),
        .load_en(load_en), .buffer_ready(buffer_ready), .mod_req(mod_req),
        .symbol_data(symbol_data), .symbol_valid(symbol_valid),
        .sym_index(sym_index), .block_done(block_done), .underrun(underrun)
    );

    multi_rate_serializer #(.DATA_W(16), .SYM_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .cipher_data(s_data),
        .load_en(s_load), .buffer_ready(s_rdy), .mod_req(s_req),
        .symbol_data(s_sym), .symbol_valid(s_valid),
        .sym_index(s_idx), .block_done(s_done), .underrun(s_und)
    );

    typedef struct {
        logic [SW-1:0] sym;
        int            idx;
    } sym_t;

    typedef struct {
        bit mr;
        bit v;
        bit rdy;
    } cyc_t;

    sym_t sym_q[$];
    cyc_t cyc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   pend_done = 1'b0;
    bit   pend_und = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] enc(input logic [SW-1:0] b);
`ifdef SERIALIZER_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    function automatic logic [3:0] enc4(input logic [3:0] b);
`ifdef SERIALIZER_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Reference: a block becomes NSYM symbols, highest chunk first.
    task automatic push_block(input logic [DW-1:0] d);
        sym_t s;
        int   sh;
        for (int k = 0; k < NS; k++) begin
            sh    = DW - SW * (k + 1);
            s.sym = enc(SW'(d >> sh));
            s.idx = k;
            sym_q.push_back(s);
        end
    endtask

    // Holding register is full exactly when more than one block is pending.
    task automatic cycle(input bit ld, input logic [DW-1:0] d, input bit mr);
        cyc_t c;
        @(posedge clk);
        #1;
        load_en     = ld;
        cipher_data = d;
        mod_req     = mr;
        c.mr  = mr;
        c.v   = (sym_q.size() > 0);
        c.rdy = (sym_q.size() <= NS);
        cyc_q.push_back(c);
        if (ld && c.rdy) push_block(d);
    endtask

    initial begin : monitor
        cyc_t c;
        sym_t s;
        forever begin
            @(negedge clk);
            if (!mon_en || cyc_q.size() == 0) begin
                pend_done = 1'b0;
                pend_und  = 1'b0;
                continue;
            end
            c = cyc_q.pop_front();
            check("block_done", block_done, pend_done);
            check("underrun", underrun, pend_und);
            pend_done = 1'b0;
            pend_und  = 1'b0;
            check("symbol_valid", symbol_valid, c.v);
            check("buffer_ready", buffer_ready, c.rdy);
            if (c.v) begin
                s = sym_q[0];
                check("symbol_data", symbol_data, s.sym);
                check("sym_index", sym_index, s.idx);
                if (c.mr) begin
                    void'(sym_q.pop_front());
                    pend_done = (s.idx == NS - 1);
                end
            end else if (c.mr) begin
                pend_und = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_symbol_data"}, symbol_data, 0);
        check({tag, "_symbol_valid"}, symbol_valid, 0);
        check({tag, "_sym_index"}, sym_index, 0);
        check({tag, "_block_done"}, block_done, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_buffer_ready"}, buffer_ready, 1);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] vec = 128'hC030_0C03_F00F_AA55_1234_5678_9ABC_DEF0;
    logic [3:0]    lsb_exp [4] = '{4'h3, 4'hC, 4'h5, 4'hA};

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        cycle(1'b1, vec, 1'b0);
        repeat (NS) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);

        cycle(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0);

        cycle(1'b1, rnd128(), 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, rnd128(), 1'b1);
        cycle(1'b1, rnd128(), 1'b0);
        repeat (2 * NS) cycle(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0);

        cycle(1'b1, rnd128(), 1'b0);
        repeat (NS - 1) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, rnd128(), 1'b1);
        repeat (NS) cycle(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 39) == 0, rnd128(), $urandom_range(0, 3) != 0);
        end
        repeat (3 * NS) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);

        cycle(1'b1, rnd128(), 1'b0);
        cycle(1'b1, rnd128(), 1'b0);
        repeat (10) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_sym_index", sym_index, 10);
        check("pre_rst_valid", symbol_valid, 1);
        check("pre_rst_ready", buffer_ready, 0);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_reset_outs("mid");
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_no_done", block_done, 0);
        end
        sym_q.delete();
        cyc_q.delete();
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, rnd128(), 1'b0);
        repeat (NS) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;

        @(posedge clk);
        #1;
        s_load = 1'b1;
        s_data = 16'hA5C3;
        @(posedge clk);
        #1;
        s_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lsb_sym", s_sym, enc4(lsb_exp[k]));
            check("lsb_idx", s_idx, k);
            check("lsb_valid", s_valid, 1);
            @(posedge clk);
            #1;
            s_req = 1'b1;
            @(posedge clk);
            #1;
            s_req = 1'b0;
            if (k == 3) begin
                check("lsb_done", s_done, 1);
                check("lsb_idle", s_valid, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_rate_serializer.md
MULTI_RATE_SERIALIZER -- requirements
Module: multi_rate_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128: width of one input block in bits.
REQ-002 The block SHALL have parameter SYM_W, default 2: bits per output symbol; legal values are 1, 2 and 4; DATA_W SHALL be a multiple of SYM_W.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 = emit from the MSB end, 0 = emit from the LSB end.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cipher_data, input, DATA_W bits: the block to serialise.
REQ-007 The block SHALL have port load_en, input, 1 bit: one-cycle load strobe for cipher_data.
REQ-008 The block SHALL have port buffer_ready, output, 1 bit: high while a load will be accepted.
REQ-009 The block SHALL have port mod_req, input, 1 bit: one-cycle pulse from the modulator to advance one symbol.
REQ-010 The block SHALL have port symbol_data, output, SYM_W bits: the current symbol.
REQ-011 The block SHALL have port symbol_valid, output, 1 bit: symbol_data holds a live symbol.
REQ-012 The block SHALL have port sym_index, output, clog2(DATA_W/SYM_W) bits: position of the current symbol within its block.
REQ-013 The block SHALL have port block_done, output, 1 bit: one-cycle pulse when the last symbol of a block is consumed.
REQ-014 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when mod_req arrives with no valid symbol.

Function
REQ-015 The block SHALL have NSYM = DATA_W/SYM_W symbols per block, and SHALL hold two DATA_W registers: an active shift register and a holding register.
REQ-016 The state machine SHALL have two states. In IDLE, symbol_valid is 0. In ACTIVE, symbol_valid is 1.
REQ-017 In IDLE, load_en SHALL load cipher_data directly into the shift register, set sym_index to 0 and enter ACTIVE; symbol_valid and symbol 0 SHALL appear after that same clock edge.
REQ-018 In ACTIVE with the holding register empty, load_en SHALL write cipher_data into the holding register.
REQ-019 buffer_ready SHALL be the registered inverse of holding-register occupancy, and SHALL be 1 in IDLE.
REQ-020 load_en while buffer_ready=0 SHALL be ignored, with no state change and data dropped.
REQ-021 When MSB_FIRST=1, symbol_data SHALL be shift[DATA_W-1 -: SYM_W] and the shift register SHALL shift left by SYM_W on each accepted mod_req.
REQ-022 When MSB_FIRST=0, symbol_data SHALL be shift[SYM_W-1:0] and the shift register SHALL shift right by SYM_W on each accepted mod_req.
REQ-023 In ACTIVE, each mod_req with sym_index < NSYM-1 SHALL advance one symbol and increment sym_index.
REQ-024 For mod_req at sym_index = NSYM-1 with the holding register full, the block SHALL pulse block_done, move the holding register into the shift register, set sym_index to 0, stay in ACTIVE and keep symbol_valid high with no gap, and set buffer_ready to 1.
REQ-025 For mod_req at sym_index = NSYM-1 with the holding register empty and load_en=1 on the same cycle, the block SHALL load cipher_data directly into the shift register with no gap and pulse block_done.
REQ-026 For mod_req at sym_index = NSYM-1 with the holding register empty and load_en=0, the block SHALL pulse block_done and enter IDLE; symbol_valid SHALL be 0 on the next cycle.
REQ-027 mod_req in IDLE SHALL pulse underrun for one cycle with no other effect.
REQ-028 load_en and a non-final mod_req on the same cycle SHALL both take effect.

Reset
REQ-029 While reset=0, the block SHALL be in IDLE, with both registers cleared and the holding register marked empty.
REQ-030 While reset=0, the outputs SHALL be: symbol_data=0, symbol_valid=0, sym_index=0, block_done=0, underrun=0, buffer_ready=1.
REQ-031 Reset asserted mid-block SHALL discard both registers without producing a block_done pulse.

Configuration
REQ-032 When macro SERIALIZER_GRAY_EN is defined, symbol_data SHALL be the Gray code of the selected bits (b ^ (b>>1)), for example 2'b11 -> 2'b10.
REQ-033 When SERIALIZER_GRAY_EN is undefined, symbol_data SHALL be the raw selected bits.
REQ-034 sym_index, the handshakes and the timing SHALL be identical in both configurations.

Verification
REQ-035 Single block: defaults, load 128'hC030_0C03_F00F_AA55_1234_5678_9ABC_DEF0 -> symbols 3,0,0,0,0,3,0,0 (sym_index 0..7); after 64 mod_req, block_done pulses once, symbol_valid=0 and buffer_ready=1.
REQ-036 Gray: same stimulus with SERIALIZER_GRAY_EN -> first symbols 2,0,0,0,0,2.
REQ-037 Back-to-back: load block A, then load block B while A is active -> buffer_ready=0 until A's 64th mod_req; symbol_valid never drops; B symbol 0 follows A symbol 63; block_done pulses twice in total.
REQ-038 Width/order: DATA_W=16, SYM_W=4, load 16'hA5C3 -> MSB_FIRST=1 yields A,5,C,3; MSB_FIRST=0 yields 3,C,5,A.
REQ-039 Error cases: mod_req in IDLE -> underrun pulses once with symbol_valid=0; load_en while buffer_ready=0 -> ignored, and the holding content is unchanged.
REQ-040 Reset: assert reset at sym_index=10 -> all outputs at reset values immediately, with no block_done pulse.
